codeconv_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one dual-mode code-converter core (binary→Gray / Gray→binary) among NREQ requesters.
- Accepts one request at a time and drives the core's start/convert/data_in, honouring the core's done protocol.
- Returns the converted word to the winning requester with a one-cycle response pulse.
- Sits between client blocks and the single converter instance.

---
 rtl/codeconv_pkg.sv | 26 ++
 rtl/codeconv_arbiter_if.sv | 37 +++
 rtl/codeconv_rr_pick.sv | 44 ++++
 rtl/codeconv_arbiter.sv | 168 ++++++++++++++++
 tb/tb_codeconv_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/codeconv_pkg.sv
// -----------------------------------------------------------------------------
// codeconv_pkg
// Shared definitions for the code-converter arbiter slice: FSM state names,
// converter mode encodings and the default data width.
// No ports (package).
// -----------------------------------------------------------------------------
package codeconv_pkg;

   // Arbiter FSM states; the arbiter keeps its state in a plain logic register
   // and uses localparam aliases of these values.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      WAIT   = 3'd2,
      SETTLE = 3'd3,
      RESP   = 3'd4
   } state_e;

   // Converter mode select values (conv_mode / req_mode bits)
   localparam logic MODE_B2G = 1'b0;
   localparam logic MODE_G2B = 1'b1;

   // Default data word width
   localparam int CODECONV_WIDTH = 8;

endpackage

// File: rtl/codeconv_arbiter_if.sv
// -----------------------------------------------------------------------------
// codeconv_arbiter_if
// Bundles the requester-side and converter-side signals of the arbiter.
//   master : the arbiter (drives gnt/rsp_*/busy/conv_start/conv_mode/conv_data)
//   slave  : the environment (requesters + converter core)
// Parameters: NREQ requesters, WIDTH-bit data words.
// -----------------------------------------------------------------------------
interface codeconv_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
);
   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       req_mode;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       rsp_valid;
   logic [WIDTH-1:0]      rsp_data;
   logic                  rsp_err;
   logic                  busy;
   logic                  conv_start;
   logic                  conv_mode;
   logic [WIDTH-1:0]      conv_data;
   logic [WIDTH-1:0]      conv_result;
   logic                  conv_done;

   modport master (
      input  req, req_mode, req_data, conv_result, conv_done,
      output gnt, rsp_valid, rsp_data, rsp_err, busy,
             conv_start, conv_mode, conv_data
   );

   modport slave (
      output req, req_mode, req_data, conv_result, conv_done,
      input  gnt, rsp_valid, rsp_data, rsp_err, busy,
             conv_start, conv_mode, conv_data
   );
endinterface

// File: rtl/codeconv_rr_pick.sv
// -----------------------------------------------------------------------------
// codeconv_rr_pick
// Combinational round-robin picker: the winner is the first set request bit
// at or after ptr, searching cyclically upward.
// Ports:
//   req        in  NREQ  request vector
//   ptr        in  IDXW  search start position
//   win_onehot out NREQ  one-hot winner (zero when no request)
//   win_idx    out IDXW  winner index (zero when no request)
//   any        out 1     at least one request present
// -----------------------------------------------------------------------------
module codeconv_rr_pick #(
   parameter int NREQ = 4,
   parameter int IDXW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] ptr,
   output logic [NREQ-1:0] win_onehot,
   output logic [IDXW-1:0] win_idx,
   output logic            any
);

   // Cyclic priority scan starting at ptr; first hit wins
   always_comb begin
      logic            found_s;
      logic [IDXW-1:0] idx_s;
      win_onehot = '0;
      win_idx    = '0;
      found_s    = 1'b0;
      idx_s      = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx_s = IDXW'((int'(ptr) + k) % NREQ);
         if (!found_s && req[idx_s]) begin
            win_onehot[idx_s] = 1'b1;
            win_idx           = idx_s;
            found_s           = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
      any = found_s;
   end

endmodule

// File: rtl/codeconv_arbiter.sv
// -----------------------------------------------------------------------------
// codeconv_arbiter
// Round-robin arbiter/sequencer sharing one binary<->Gray converter core among
// NREQ requesters. One transaction in flight at a time:
//   IDLE -> ISSUE (gnt + conv_start) -> WAIT (for conv_done) -> SETTLE
//   (capture conv_result) -> RESP (rsp_valid pulse) -> IDLE
// Ports:
//   clk      in  clock, rising edge
//   reset_n  in  asynchronous active-low reset
//   bus      codeconv_arbiter_if.master (req/req_mode/req_data, gnt,
//            rsp_valid/rsp_data/rsp_err, busy, conv_start/conv_mode/conv_data,
//            conv_result/conv_done)
// Optional feature macro: CODECONV_ARB_TIMEOUT_EN
//   defined   : WAIT gives up after TIMEOUT cycles, responding with rsp_err=1
//               and rsp_data=0
//   undefined : WAIT holds indefinitely, rsp_err stays 0
// -----------------------------------------------------------------------------
module codeconv_arbiter
   import codeconv_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int WIDTH   = CODECONV_WIDTH,
   parameter int TIMEOUT = 64
) (
   input logic                clk,
   input logic                reset_n,
   codeconv_arbiter_if.master bus
);

   localparam int IDXW = $clog2(NREQ);

   localparam logic [2:0] ST_IDLE   = IDLE;
   localparam logic [2:0] ST_ISSUE  = ISSUE;
   localparam logic [2:0] ST_WAIT   = WAIT;
   localparam logic [2:0] ST_SETTLE = SETTLE;
   localparam logic [2:0] ST_RESP   = RESP;

   logic [2:0]       state_r;
   logic [2:0]       state_nxt_s;
   logic [IDXW-1:0]  ptr_r;
   logic [NREQ-1:0]  win_onehot_r;
   logic [NREQ-1:0]  gnt_r;
   logic [NREQ-1:0]  rsp_valid_r;
   logic [WIDTH-1:0] rsp_data_r;
   logic             rsp_err_r;
   logic             busy_r;
   logic             conv_start_r;
   logic             conv_mode_r;
   logic [WIDTH-1:0] conv_data_r;

   logic [NREQ-1:0]  pick_onehot_s;
   logic [IDXW-1:0]  pick_idx_s;
   logic             pick_any_s;
   logic             timeout_s;

   codeconv_rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
      .req        (bus.req),
      .ptr        (ptr_r),
      .win_onehot (pick_onehot_s),
      .win_idx    (pick_idx_s),
      .any        (pick_any_s)
   );

`ifdef CODECONV_ARB_TIMEOUT_EN
   localparam int CNTW = $clog2(TIMEOUT) + 1;
   logic [CNTW-1:0] wait_cnt_r;

   // WAIT-cycle counter: cleared while entering WAIT, counts each WAIT cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt_r <= '0;
      end else if (state_r == ST_ISSUE) begin
         wait_cnt_r <= '0;
      end else if (state_r == ST_WAIT) begin
         wait_cnt_r <= wait_cnt_r + CNTW'(1);
      end
   end

   assign timeout_s = (wait_cnt_r == CNTW'(TIMEOUT - 1));
`else
   assign timeout_s = 1'b0;
`endif

   // Next-state logic; a stale-high conv_done blocks new grants in IDLE
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (pick_any_s && !bus.conv_done) state_nxt_s = ST_ISSUE;
            else                              state_nxt_s = ST_IDLE;
         end
         ST_ISSUE:  state_nxt_s = ST_WAIT;
         ST_WAIT: begin
            if (bus.conv_done)  state_nxt_s = ST_SETTLE;
            else if (timeout_s) state_nxt_s = ST_RESP;
            else                state_nxt_s = ST_WAIT;
         end
         ST_SETTLE: state_nxt_s = ST_RESP;
         ST_RESP:   state_nxt_s = ST_IDLE;
         default:   state_nxt_s = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_r <= ST_IDLE;
      else          state_r <= state_nxt_s;
   end

   // Pointer, operand latches and registered outputs; pulses default low
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_r        <= '0;
         win_onehot_r <= '0;
         gnt_r        <= '0;
         rsp_valid_r  <= '0;
         rsp_data_r   <= '0;
         rsp_err_r    <= 1'b0;
         busy_r       <= 1'b0;
         conv_start_r <= 1'b0;
         conv_mode_r  <= 1'b0;
         conv_data_r  <= '0;
      end else begin
         gnt_r        <= '0;
         conv_start_r <= 1'b0;
         rsp_valid_r  <= '0;
         busy_r       <= (state_nxt_s != ST_IDLE);
         case (state_r)
            ST_IDLE: begin
               if (state_nxt_s == ST_ISSUE) begin
                  gnt_r        <= pick_onehot_s;
                  conv_start_r <= 1'b1;
                  win_onehot_r <= pick_onehot_s;
                  conv_mode_r  <= bus.req_mode[pick_idx_s];
                  conv_data_r  <= bus.req_data[int'(pick_idx_s)*WIDTH +: WIDTH];
                  ptr_r        <= (pick_idx_s == IDXW'(NREQ - 1)) ?
                                  '0 : pick_idx_s + IDXW'(1);
               end
            end
            ST_WAIT: begin
               // Timeout skips SETTLE and answers with an error response
               if (state_nxt_s == ST_RESP) begin
                  rsp_valid_r <= win_onehot_r;
                  rsp_data_r  <= '0;
                  rsp_err_r   <= 1'b1;
               end
            end
            ST_SETTLE: begin
               rsp_valid_r <= win_onehot_r;
               rsp_data_r  <= bus.conv_result;
               rsp_err_r   <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.gnt        = gnt_r;
   assign bus.rsp_valid  = rsp_valid_r;
   assign bus.rsp_data   = rsp_data_r;
   assign bus.rsp_err    = rsp_err_r;
   assign bus.busy       = busy_r;
   assign bus.conv_start = conv_start_r;
   assign bus.conv_mode  = conv_mode_r;
   assign bus.conv_data  = conv_data_r;

endmodule

// File: tb/tb_codeconv_arbiter.sv
// -----------------------------------------------------------------------------
// tb_codeconv_arbiter
// Self-checking bench for codeconv_arbiter (NREQ=4, WIDTH=8, TIMEOUT=16).
// Acts as requesters and converter core. Transaction-level reference model:
// a round-robin pointer plus arithmetic bin<->Gray conversion.
// The timeout sequence runs only when CODECONV_ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_codeconv_arbiter;
   import codeconv_pkg::*;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   codeconv_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   codeconv_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.master)
   );

   int n_checks  = 0;
   int n_fail    = 0;
   int model_ptr = 0;

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  mode;
      logic [31:0] data;
      logic [3:0]  exp_gnt;
      logic [7:0]  exp_res;
   } vec_t;

   vec_t tbl [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Behavioural converter: Gray = b ^ (b>>1); binary bit i = XOR of gray[7:i]
   function automatic logic [7:0] ref_conv(input logic mode, input logic [7:0] v);
      logic [7:0] r;
      logic       acc;
      if (mode == MODE_B2G) begin
         r = v ^ (v >> 1);
      end else begin
         acc = 1'b0;
         r   = 8'h00;
         for (int b = 7; b >= 0; b--) begin
            acc  = acc ^ v[b];
            r[b] = acc;
         end
      end
      return r;
   endfunction

   // Round-robin reference: first set bit at/after model_ptr
   function automatic int model_pick(input logic [3:0] r);
      for (int k = 0; k < NREQ; k++) begin
         if (r[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string name);
      check({name, ":gnt"},        32'(bus.gnt),        32'h0);
      check({name, ":rsp_valid"},  32'(bus.rsp_valid),  32'h0);
      check({name, ":rsp_data"},   32'(bus.rsp_data),   32'h0);
      check({name, ":rsp_err"},    32'(bus.rsp_err),    32'h0);
      check({name, ":busy"},       32'(bus.busy),       32'h0);
      check({name, ":conv_start"}, 32'(bus.conv_start), 32'h0);
      check({name, ":conv_mode"},  32'(bus.conv_mode),  32'h0);
      check({name, ":conv_data"},  32'(bus.conv_data),  32'h0);
   endtask

   task automatic do_reset();
      reset_n          = 1'b0;
      bus.req          = 4'h0;
      bus.req_mode     = 4'h0;
      bus.req_data     = 32'h0;
      bus.conv_done    = 1'b0;
      bus.conv_result  = 8'h00;
      repeat (2) tick();
      reset_n   = 1'b1;
      model_ptr = 0;
      tick();
   endtask

   // One full transaction from IDLE; core answers after lat WAIT cycles
   task automatic run_txn(input string name, input logic [3:0] r, input logic [3:0] m,
                          input logic [31:0] d, input int lat, input bit hold,
                          input logic [3:0] exp_gnt, input logic [7:0] exp_res);
      int         w;
      logic [7:0] op;
      w = 0;
      for (int i = 0; i < NREQ; i++) if (exp_gnt[i]) w = i;
      op = d[w*WIDTH +: WIDTH];
      bus.req       = r;
      bus.req_mode  = m;
      bus.req_data  = d;
      bus.conv_done = 1'b0;
      tick();
      check({name, ":gnt"},        32'(bus.gnt),        32'(exp_gnt));
      check({name, ":conv_start"}, 32'(bus.conv_start), 32'h1);
      check({name, ":conv_mode"},  32'(bus.conv_mode),  32'(m[w]));
      check({name, ":conv_data"},  32'(bus.conv_data),  32'(op));
      check({name, ":busy"},       32'(bus.busy),       32'h1);
      if (!hold) bus.req = 4'h0;
      tick();
      check({name, ":gnt_pulse"},   32'(bus.gnt),        32'h0);
      check({name, ":start_pulse"}, 32'(bus.conv_start), 32'h0);
      repeat (lat) begin
         tick();
         check({name, ":wait_rsp"}, 32'(bus.rsp_valid), 32'h0);
      end
      bus.conv_result = ref_conv(m[w], op);
      bus.conv_done   = 1'b1;
      tick();
      check({name, ":settle_rsp"}, 32'(bus.rsp_valid), 32'h0);
      tick();
      check({name, ":rsp_valid"}, 32'(bus.rsp_valid), 32'(exp_gnt));
      check({name, ":rsp_data"},  32'(bus.rsp_data),  32'(exp_res));
      check({name, ":rsp_err"},   32'(bus.rsp_err),   32'h0);
      bus.conv_done   = 1'b0;
      bus.conv_result = ~bus.conv_result;
      tick();
      check({name, ":rsp_pulse"}, 32'(bus.rsp_valid), 32'h0);
      check({name, ":idle_busy"}, 32'(bus.busy),      32'h0);
      model_ptr = (w + 1) % NREQ;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  r;
      logic [3:0]  m;
      logic [31:0] d;
      int          w;
      logic [7:0]  res;

      tbl[0] = '{req: 4'b0100, mode: 4'b0000, data: 32'h11A3_2233, exp_gnt: 4'b0100, exp_res: 8'hF2};
      tbl[1] = '{req: 4'b0001, mode: 4'b0001, data: 32'h0000_00F2, exp_gnt: 4'b0001, exp_res: 8'hA3};
      tbl[2] = '{req: 4'b0010, mode: 4'b0000, data: 32'h0000_5500, exp_gnt: 4'b0010, exp_res: 8'h7F};
      tbl[3] = '{req: 4'b1011, mode: 4'b1000, data: 32'hC000_0000, exp_gnt: 4'b1000, exp_res: 8'h80};
      tbl[4] = '{req: 4'b0011, mode: 4'b0000, data: 32'h0000_000F, exp_gnt: 4'b0001, exp_res: 8'h08};

      do_reset();
      check_all_zero("reset");

      // Directed table
      for (int i = 0; i < 5; i++) begin
         run_txn($sformatf("tbl%0d", i), tbl[i].req, tbl[i].mode, tbl[i].data,
                 i, 1'b0, tbl[i].exp_gnt, tbl[i].exp_res);
      end

      // Fairness: all requests held, order 0,1,2,3,0,1,2,3
      do_reset();
      for (int k = 0; k < 8; k++) begin
         d = $urandom;
         m = 4'($urandom);
         w = k % NREQ;
         run_txn($sformatf("fair%0d", k), 4'b1111, m, d, 0, 1'b1,
                 4'(1 << w), ref_conv(m[w], d[w*WIDTH +: WIDTH]));
      end

      // Stale done in IDLE blocks granting until it falls
      bus.req       = 4'b0010;
      bus.conv_done = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("stale:gnt",  32'(bus.gnt),  32'h0);
         check("stale:busy", 32'(bus.busy), 32'h0);
      end
      run_txn("stale_go", 4'b0010, 4'b0000, 32'h0000_3C00, 1, 1'b0, 4'b0010, 8'h22);

      // Reset during WAIT aborts; late core completion is ignored
      bus.req      = 4'b0100;
      bus.req_mode = 4'b0000;
      bus.req_data = 32'h0099_0000;
      tick();
      check("rstwait:gnt", 32'(bus.gnt), 32'h4);
      bus.req = 4'h0;
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      check_all_zero("rstwait");
      tick();
      reset_n   = 1'b1;
      model_ptr = 0;
      bus.conv_result = 8'hAA;
      bus.conv_done   = 1'b1;
      tick();
      tick();
      check("rstwait:no_rsp", 32'(bus.rsp_valid), 32'h0);
      check("rstwait:idle",   32'(bus.busy),      32'h0);
      bus.conv_done = 1'b0;
      run_txn("rst_ptr0", 4'b1001, 4'b0000, 32'h0000_0001, 0, 1'b0, 4'b0001, 8'h01);
      run_txn("rst_req3", 4'b1000, 4'b1000, 32'h0300_0000, 2, 1'b0, 4'b1000, 8'h02);

      // Randomized transactions against the reference model
      for (int k = 0; k < 40; k++) begin
         r   = 4'($urandom_range(1, 15));
         m   = 4'($urandom);
         d   = $urandom;
         w   = model_pick(r);
         res = ref_conv(m[w], d[w*WIDTH +: WIDTH]);
         run_txn($sformatf("rnd%0d", k), r, m, d, $urandom_range(0, 6),
                 1'($urandom), 4'(1 << w), res);
      end

`ifdef CODECONV_ARB_TIMEOUT_EN
      // Timeout: conv_done never rises; error response after 16 WAIT cycles
      r = 4'b0100;
      w = model_pick(r);
      bus.req      = r;
      bus.req_data = 32'h00A3_0000;
      tick();
      check("tmo:gnt", 32'(bus.gnt), 32'(4'(1 << w)));
      bus.req = 4'h0;
      tick();
      for (int k = 0; k < 15; k++) begin
         tick();
         check("tmo:early_rsp", 32'(bus.rsp_valid), 32'h0);
      end
      tick();
      check("tmo:rsp_valid", 32'(bus.rsp_valid), 32'(4'(1 << w)));
      check("tmo:rsp_err",   32'(bus.rsp_err),   32'h1);
      check("tmo:rsp_data",  32'(bus.rsp_data),  32'h0);
      tick();
      check("tmo:idle", 32'(bus.busy), 32'h0);
      model_ptr = (w + 1) % NREQ;
      run_txn("tmo_after", 4'b0001, 4'b0000, 32'h0000_0055, 0, 1'b0, 4'b0001, 8'h7F);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
